// File: rtl/sprite_pkg.sv
// sprite_pkg: shared scheduler state encoding, index width and visibility test
package sprite_pkg;
   typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
   function automatic logic spr_visible(input logic vis, input int diff, input int height);
      return vis && diff >= 0 && diff < height;
   endfunction
endpackage

// File: rtl/sprite_table.sv
// sprite_table: double-buffered sprite table, shadow written any time, active copied on frame
module sprite_table #(
   parameter int CORDW = 10,
   parameter int N_SPR = 8,
   parameter int IDXW = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    frame,
   input  logic                    wr_en,
   input  logic [IDXW-1:0]         wr_idx,
   input  logic signed [CORDW-1:0] wr_x,
   input  logic signed [CORDW-1:0] wr_y,
   input  logic                    wr_vis,
   input  logic [IDXW-1:0]         rd_idx,
   output logic signed [CORDW-1:0] rd_x,
   output logic signed [CORDW-1:0] rd_y,
   output logic                    rd_vis
);
   logic signed [CORDW-1:0] sh_x [N_SPR];
   logic signed [CORDW-1:0] sh_y [N_SPR];
   logic signed [CORDW-1:0] act_x [N_SPR];
   logic signed [CORDW-1:0] act_y [N_SPR];
   logic [N_SPR-1:0] sh_vis, act_vis, hit;
   always_comb begin
      hit = '0;
      for (int k = 0; k < N_SPR; k++) hit[k] = wr_en && wr_idx == IDXW'(k);
   end
   always_ff @(posedge clk) begin
      for (int k = 0; k < N_SPR; k++) begin
         if (rst) begin
            sh_x[k] <= '0;
            sh_y[k] <= '0;
            sh_vis[k] <= 1'b0;
            act_x[k] <= '0;
            act_y[k] <= '0;
            act_vis[k] <= 1'b0;
         end else begin
            if (hit[k]) begin
               sh_x[k] <= wr_x;
               sh_y[k] <= wr_y;
               sh_vis[k] <= wr_vis;
            end
            // a write coinciding with frame must reach the active copy too
            if (frame) begin
               act_x[k] <= hit[k] ? wr_x : sh_x[k];
               act_y[k] <= hit[k] ? wr_y : sh_y[k];
               act_vis[k] <= hit[k] ? wr_vis : sh_vis[k];
            end
         end
      end
   end
   assign rd_x = act_x[rd_idx];
   assign rd_y = act_y[rd_idx];
   assign rd_vis = act_vis[rd_idx];
endmodule

// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: scans the active table each line and publishes up to SLOTS visible sprites
module sprite_line_scheduler import sprite_pkg::*; #(
   parameter int CORDW = 10,
   parameter int N_SPR = 8,
   parameter int SLOTS = 4,
   parameter int SPR_HEIGHT = 8,
   parameter int SPR_SCALE = 0,
   localparam int IDXW = idx_w(N_SPR)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    frame,
   input  logic                    line,
   input  logic signed [CORDW-1:0] sy,
   input  logic                    wr_en,
   input  logic [IDXW-1:0]         wr_idx,
   input  logic signed [CORDW-1:0] wr_x,
   input  logic signed [CORDW-1:0] wr_y,
   input  logic                    wr_vis,
   output logic [SLOTS-1:0]        slot_valid,
   output logic [SLOTS*IDXW-1:0]   slot_idx,
   output logic [SLOTS*CORDW-1:0]  slot_x,
   output logic [SLOTS*CORDW-1:0]  slot_y,
   output logic                    ovf_line,
   output logic                    ovf_frame,
   output logic                    late
);
   localparam int FW = $clog2(SLOTS + 1);
   state_t state;
   logic [IDXW-1:0] i;
   logic [FW-1:0] fill;
   logic signed [CORDW-1:0] ny, rd_x, rd_y, diff_raw, diff;
   logic rd_vis, hit, w_ovf;
   logic [SLOTS-1:0] w_valid;
   logic [SLOTS*IDXW-1:0] w_idx;
   logic [SLOTS*CORDW-1:0] w_x, w_y;
   sprite_table #(.CORDW(CORDW), .N_SPR(N_SPR), .IDXW(IDXW)) u_table (
      .clk(clk), .rst(rst), .frame(frame), .wr_en(wr_en), .wr_idx(wr_idx),
      .wr_x(wr_x), .wr_y(wr_y), .wr_vis(wr_vis), .rd_idx(i),
      .rd_x(rd_x), .rd_y(rd_y), .rd_vis(rd_vis)
   );
   assign diff_raw = ny - rd_y;
   assign diff = diff_raw >>> SPR_SCALE;
   assign hit = spr_visible(rd_vis, int'(diff), SPR_HEIGHT);
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         i <= '0;
         fill <= '0;
         ny <= '0;
         w_valid <= '0;
         w_idx <= '0;
         w_x <= '0;
         w_y <= '0;
         w_ovf <= 1'b0;
         slot_valid <= '0;
         slot_idx <= '0;
         slot_x <= '0;
         slot_y <= '0;
         ovf_line <= 1'b0;
         ovf_frame <= 1'b0;
         late <= 1'b0;
      end else if (line) begin
         // an interrupted scan publishes nothing rather than a partial list
         slot_valid <= state == SCAN ? '0 : w_valid;
         slot_idx <= state == SCAN ? '0 : w_idx;
         slot_x <= state == SCAN ? '0 : w_x;
         slot_y <= state == SCAN ? '0 : w_y;
         ovf_line <= state != SCAN && w_ovf;
         ovf_frame <= (state != SCAN && w_ovf) || (ovf_frame && !frame);
         late <= state == SCAN;
         w_valid <= '0;
         w_idx <= '0;
         w_x <= '0;
         w_y <= '0;
         w_ovf <= 1'b0;
         fill <= '0;
         ny <= sy + CORDW'(1);
         i <= '0;
         state <= SCAN;
      end else begin
         if (frame) ovf_frame <= 1'b0;
         if (state == SCAN) begin
            if (hit && fill == FW'(SLOTS)) w_ovf <= 1'b1;
            for (int s = 0; s < SLOTS; s++) begin
               if (hit && fill == FW'(s)) begin
                  w_valid[s] <= 1'b1;
                  w_idx[s*IDXW +: IDXW] <= i;
                  w_x[s*CORDW +: CORDW] <= rd_x;
                  w_y[s*CORDW +: CORDW] <= rd_y;
                  fill <= fill + FW'(1);
               end
            end
            i <= i + IDXW'(1);
            if (i == IDXW'(N_SPR - 1)) state <= HOLD;
         end
      end
   end
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb_sprite_line_scheduler: directed vector bench for the sprite line scheduler
module tb_sprite_line_scheduler;
   logic clk = 1'b0;
   logic rst, frame, line, wr_en, wr_vis;
   logic signed [9:0] sy, wr_x, wr_y;
   logic [2:0] wr_idx;
   logic [3:0] slot_valid, sc_valid;
   logic [11:0] slot_idx, sc_idx;
   logic [39:0] slot_x, slot_y, sc_x, sc_y;
   logic ovf_line, ovf_frame, late, sc_ovf_line, sc_ovf_frame, sc_late;
   int checks = 0;
   int passes = 0;

   typedef struct {
      logic signed [9:0] sy;
      logic [3:0] valid;
      logic [11:0] idx;
      logic [9:0] x0;
      logic [9:0] y0;
      logic ovf;
   } vec_t;
   vec_t v [8];

   sprite_line_scheduler u_dut (
      .clk(clk), .rst(rst), .frame(frame), .line(line), .sy(sy),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y), .wr_vis(wr_vis),
      .slot_valid(slot_valid), .slot_idx(slot_idx), .slot_x(slot_x), .slot_y(slot_y),
      .ovf_line(ovf_line), .ovf_frame(ovf_frame), .late(late)
   );
   sprite_line_scheduler #(.SPR_SCALE(1)) u_sc (
      .clk(clk), .rst(rst), .frame(frame), .line(line), .sy(sy),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y), .wr_vis(wr_vis),
      .slot_valid(sc_valid), .slot_idx(sc_idx), .slot_x(sc_x), .slot_y(sc_y),
      .ovf_line(sc_ovf_line), .ovf_frame(sc_ovf_frame), .late(sc_late)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic wr(input logic [2:0] idx, input logic signed [9:0] x, input logic signed [9:0] y,
                     input logic vis, input logic f);
      wr_en = 1'b1;
      wr_idx = idx;
      wr_x = x;
      wr_y = y;
      wr_vis = vis;
      frame = f;
      tick;
      wr_en = 1'b0;
      frame = 1'b0;
   endtask

   task automatic pulse_frame;
      frame = 1'b1;
      tick;
      frame = 1'b0;
   endtask

   task automatic pulse_line(input logic signed [9:0] s);
      line = 1'b1;
      sy = s;
      tick;
      line = 1'b0;
   endtask

   // scans for ny = s+1, then publishes that list
   task automatic sched(input logic signed [9:0] s);
      repeat (12) tick;
      pulse_line(s);
      repeat (12) tick;
      pulse_line(s);
   endtask

   initial begin
      rst = 1'b1;
      frame = 1'b0;
      line = 1'b0;
      sy = '0;
      wr_en = 1'b0;
      wr_idx = '0;
      wr_x = '0;
      wr_y = '0;
      wr_vis = 1'b0;
      repeat (2) tick;
      chk("rst_valid", 32'(slot_valid), 32'h0);
      chk("rst_idx", 32'(slot_idx), 32'h0);
      chk("rst_ovf_line", 32'(ovf_line), 32'h0);
      chk("rst_ovf_frame", 32'(ovf_frame), 32'h0);
      chk("rst_late", 32'(late), 32'h0);
      rst = 1'b0;
      tick;
      pulse_line(10'sd5);
      chk("first_line_empty", 32'(slot_valid), 32'h0);

      wr(3'd0, 10'sd5, 10'sd0, 1'b1, 1'b0);
      wr(3'd1, 10'sd6, 10'sd0, 1'b1, 1'b0);
      wr(3'd2, 10'sd100, 10'sd10, 1'b1, 1'b0);
      wr(3'd3, 10'sd7, 10'sd0, 1'b0, 1'b0);
      wr(3'd4, 10'sd8, 10'sd2, 1'b1, 1'b0);
      wr(3'd5, 10'sd9, 10'sd1, 1'b1, 1'b0);
      wr(3'd6, 10'sd11, 10'sd4, 1'b1, 1'b0);
      wr(3'd7, 10'sd12, -10'sd5, 1'b1, 1'b0);
      pulse_frame;

      v[0] = '{10'sd2,  4'b1111, 12'hB08, 10'd5,   10'd0,   1'b0};
      v[1] = '{10'sd9,  4'b0011, 12'h032, 10'd100, 10'd10,  1'b0};
      v[2] = '{10'sd16, 4'b0001, 12'h002, 10'd100, 10'd10,  1'b0};
      v[3] = '{10'sd17, 4'b0000, 12'h000, 10'd0,   10'd0,   1'b0};
      v[4] = '{-10'sd6, 4'b0001, 12'h007, 10'd12,  10'h3FB, 1'b0};
      v[5] = '{-10'sd1, 4'b0111, 12'h1C8, 10'd5,   10'd0,   1'b0};
      v[6] = '{10'sd11, 4'b0001, 12'h002, 10'd100, 10'd10,  1'b0};
      v[7] = '{10'sd1,  4'b1111, 12'hB08, 10'd5,   10'd0,   1'b1};
      for (int n = 0; n < 8; n++) begin
         sched(v[n].sy);
         chk($sformatf("v%0d_valid", n), 32'(slot_valid), 32'(v[n].valid));
         chk($sformatf("v%0d_idx", n), 32'(slot_idx), 32'(v[n].idx));
         chk($sformatf("v%0d_x0", n), 32'(slot_x[9:0]), 32'(v[n].x0));
         chk($sformatf("v%0d_y0", n), 32'(slot_y[9:0]), 32'(v[n].y0));
         chk($sformatf("v%0d_ovf_line", n), 32'(ovf_line), 32'(v[n].ovf));
         chk($sformatf("v%0d_late", n), 32'(late), 32'h0);
      end
      chk("ovf_frame_set", 32'(ovf_frame), 32'h1);
      pulse_frame;
      chk("ovf_frame_cleared", 32'(ovf_frame), 32'h0);

      wr(3'd3, 10'sd33, 10'sd20, 1'b1, 1'b0);
      pulse_frame;
      sched(10'sd34);
      chk("scale_ny35_valid", 32'(sc_valid), 32'h1);
      chk("scale_ny35_idx", 32'(sc_idx), 32'h003);
      sched(10'sd35);
      chk("scale_ny36_valid", 32'(sc_valid), 32'h0);
      sched(10'sd18);
      chk("scale_ny19_valid", 32'(sc_valid), 32'h3);
      chk("scale_ny19_idx", 32'(sc_idx), 32'h032);

      wr(3'd3, 10'sd33, 10'sd50, 1'b1, 1'b0);
      sched(10'sd19);
      chk("dbuf_old_valid", 32'(slot_valid), 32'h1);
      chk("dbuf_old_idx", 32'(slot_idx), 32'h003);
      chk("dbuf_old_y", 32'(slot_y[9:0]), 32'd20);
      wr(3'd3, 10'sd33, 10'sd50, 1'b1, 1'b1);
      sched(10'sd49);
      chk("dbuf_new_valid", 32'(slot_valid), 32'h1);
      chk("dbuf_new_idx", 32'(slot_idx), 32'h003);
      chk("dbuf_new_y", 32'(slot_y[9:0]), 32'd50);

      repeat (12) tick;
      pulse_line(10'sd10);
      repeat (2) tick;
      pulse_line(10'sd49);
      chk("abort_valid", 32'(slot_valid), 32'h0);
      chk("abort_idx", 32'(slot_idx), 32'h0);
      chk("abort_late", 32'(late), 32'h1);
      chk("abort_ovf_line", 32'(ovf_line), 32'h0);
      repeat (12) tick;
      pulse_line(10'sd49);
      chk("after_abort_valid", 32'(slot_valid), 32'h1);
      chk("after_abort_idx", 32'(slot_idx), 32'h003);
      chk("after_abort_y", 32'(slot_y[9:0]), 32'd50);
      chk("after_abort_late", 32'(late), 32'h0);

      pulse_line(10'sd49);
      repeat (2) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("midrst_valid", 32'(slot_valid), 32'h0);
      chk("midrst_idx", 32'(slot_idx), 32'h0);
      chk("midrst_y", 32'(slot_y[9:0]), 32'h0);
      pulse_line(10'sd49);
      chk("midrst_first_empty", 32'(slot_valid), 32'h0);
      repeat (12) tick;
      pulse_line(10'sd49);
      chk("midrst_table_cleared", 32'(slot_valid), 32'h0);
      chk("midrst_late", 32'(late), 32'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
